id_stage_p: RTL and testbench

Parametrised instruction-decode pipeline stage for the GCD CPU: decodes one 32-bit MIPS-subset instruction per cycle, reads a reset-initialised register file, and registers control, operands and jump targets into the ID/EX boundary. Compared with the current decode stage it adds:
- XLEN/NREG parameters
- load-use interlock with a stall output to IF
- flush/bubble insertion
- illegal-opcode reporting
- `jal` linking through the write-back path instead of a direct side-write

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_regfile.sv | 48 ++++
 rtl/id_stage_p.sv | 181 ++++++++++++++++++
 tb/tb_id_stage_p.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants, ALU codes and the ID/EX control bundle
// for the GCD CPU instruction-decode stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MUL = 6'd1;
  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_MUL   = 3'd5,
    ALU_EQ    = 3'd6,
    ALU_PASSB = 3'd7
  } aluctr_e;

  typedef struct packed {
    logic    memtoreg;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    jr;
    aluctr_e aluctr;
  } dx_ctrl_t;

  localparam dx_ctrl_t BUBBLE = dx_ctrl_t'(10'd0);

endpackage

// File: rtl/id_regfile.sv
// Register file: one write port, three combinational reads.
// Define ID_BYPASS_EN to forward a same-cycle write to the reads.
module id_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 508,
  localparam int RW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  input  logic [RW-1:0]   ra3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] rd3
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr;

  assign wr = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
    end else if (wr) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
    rd3 = (ra3 == '0) ? '0 : regs[ra3];
`ifdef ID_BYPASS_EN
    if (wr && wa == ra1) rd1 = wd;
    if (wr && wa == ra2) rd2 = wd;
    if (wr && wa == ra3) rd3 = wd;
`endif
  end

endmodule

// File: rtl/id_stage_p.sv
// Decode stage: register read, control decode, load-use interlock and
// ID/EX register. Same-cycle WB forwarding enabled by ID_BYPASS_EN.
module id_stage_p
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 508,
  localparam int RW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_ir,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_memread,
  input  logic [RW-1:0]   ex_rd,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            dx_valid,
  output logic            dx_memtoreg,
  output logic            dx_regwrite,
  output logic            dx_memread,
  output logic            dx_memwrite,
  output logic            dx_branch,
  output logic            dx_jump,
  output logic            dx_jr,
  output logic [2:0]      dx_aluctr,
  output logic [XLEN-1:0] dx_pc,
  output logic [XLEN-1:0] dx_a,
  output logic [XLEN-1:0] dx_b,
  output logic [XLEN-1:0] dx_md,
  output logic [15:0]     dx_imm,
  output logic [RW-1:0]   dx_rd,
  output logic [XLEN-1:0] dx_jt,
  output logic            dx_illegal,
  input  logic [RW-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  logic [5:0]      op, fn;
  logic [RW-1:0]   rs, rt, rd_f;
  logic [15:0]     imm;
  logic [XLEN-1:0] sext, rs_v, rt_v;
  dx_ctrl_t        ctrl, ctrl_q;
  logic [XLEN-1:0] b, jt;
  logic [RW-1:0]   rdi;
  logic            ill, live;

  assign op   = if_ir[31:26];
  assign fn   = if_ir[5:0];
  assign rs   = if_ir[21 +: RW];
  assign rt   = if_ir[16 +: RW];
  assign rd_f = if_ir[11 +: RW];
  assign imm  = if_ir[15:0];
  assign sext = {{(XLEN-16){imm[15]}}, imm};

  id_regfile #(
    .XLEN(XLEN), .NREG(NREG),
    .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
  ) u_rf (
    .clk(clk), .rst(rst),
    .we(wb_we), .wa(wb_rd), .wd(wb_data),
    .ra1(rs), .ra2(rt), .ra3(dbg_sel),
    .rd1(rs_v), .rd2(rt_v), .rd3(dbg_data)
  );

  // rt is only a true source for R-type, beq and sw
  assign id_stall = if_valid && !flush && ex_memread
                 && (ex_rd != '0)
                 && ((ex_rd == rs)
                  || ((ex_rd == rt)
                   && (op == OP_RTYPE || op == OP_BEQ
                    || op == OP_SW)));

  assign live = if_valid && !flush && !id_stall;

  always_comb begin
    ctrl = BUBBLE;
    b    = rt_v;
    rdi  = rd_f;
    jt   = '0;
    ill  = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        unique case (1'b1)
          fn == FN_ADD: ctrl.aluctr = ALU_ADD;
          fn == FN_SUB: ctrl.aluctr = ALU_SUB;
          fn == FN_AND: ctrl.aluctr = ALU_AND;
          fn == FN_OR:  ctrl.aluctr = ALU_OR;
          fn == FN_SLT: ctrl.aluctr = ALU_SLT;
          fn == FN_MUL: ctrl.aluctr = ALU_MUL;
          fn == FN_JR: begin
            ctrl.regwrite = 1'b0;
            ctrl.jump     = 1'b1;
            ctrl.jr       = 1'b1;
            jt            = rs_v;
          end
          default: begin
            ctrl = BUBBLE;
            ill  = 1'b1;
          end
        endcase
      end
      op == OP_ADDI: begin
        b             = sext;
        ctrl.regwrite = 1'b1;
        rdi           = rt;
      end
      op == OP_LW: begin
        b             = sext;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        rdi           = rt;
      end
      op == OP_SW: begin
        b             = sext;
        ctrl.memwrite = 1'b1;
      end
      op == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluctr = ALU_EQ;
        jt          = if_pc + (sext << 2);
      end
      op == OP_J: begin
        ctrl.jump = 1'b1;
        jt = {if_pc[XLEN-1:28], if_ir[25:0], 2'b00};
      end
      op == OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluctr   = ALU_PASSB;
        rdi           = '1;
        b             = if_pc;
        jt = {if_pc[XLEN-1:28], if_ir[25:0], 2'b00};
      end
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !live || ill) begin
      dx_valid <= 1'b0;
      ctrl_q   <= BUBBLE;
      dx_pc    <= '0;
      dx_a     <= '0;
      dx_b     <= '0;
      dx_md    <= '0;
      dx_imm   <= '0;
      dx_rd    <= '0;
      dx_jt    <= '0;
    end else begin
      dx_valid <= 1'b1;
      ctrl_q   <= ctrl;
      dx_pc    <= if_pc;
      dx_a     <= rs_v;
      dx_b     <= b;
      dx_md    <= rt_v;
      dx_imm   <= imm;
      dx_rd    <= rdi;
      dx_jt    <= jt;
    end
    dx_illegal <= !rst && live && ill;
  end

  assign dx_memtoreg = ctrl_q.memtoreg;
  assign dx_regwrite = ctrl_q.regwrite;
  assign dx_memread  = ctrl_q.memread;
  assign dx_memwrite = ctrl_q.memwrite;
  assign dx_branch   = ctrl_q.branch;
  assign dx_jump     = ctrl_q.jump;
  assign dx_jr       = ctrl_q.jr;
  assign dx_aluctr   = ctrl_q.aluctr;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed-vector bench for id_stage_p with hand-computed expectations.
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_stall;
  logic        dx_valid;
  logic        dx_memtoreg, dx_regwrite, dx_memread;
  logic        dx_memwrite, dx_branch, dx_jump, dx_jr;
  logic [2:0]  dx_aluctr;
  logic [31:0] dx_pc, dx_a, dx_b, dx_md, dx_jt;
  logic [15:0] dx_imm;
  logic [4:0]  dx_rd;
  logic        dx_illegal;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [6:0]  ctl;
  logic [31:0] byp;

  always #5 clk = ~clk;

  id_stage_p dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
    .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_stall(id_stall), .dx_valid(dx_valid),
    .dx_memtoreg(dx_memtoreg), .dx_regwrite(dx_regwrite),
    .dx_memread(dx_memread), .dx_memwrite(dx_memwrite),
    .dx_branch(dx_branch), .dx_jump(dx_jump), .dx_jr(dx_jr),
    .dx_aluctr(dx_aluctr), .dx_pc(dx_pc),
    .dx_a(dx_a), .dx_b(dx_b), .dx_md(dx_md),
    .dx_imm(dx_imm), .dx_rd(dx_rd), .dx_jt(dx_jt),
    .dx_illegal(dx_illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  assign ctl = {dx_memtoreg, dx_regwrite, dx_memread,
                dx_memwrite, dx_branch, dx_jump, dx_jr};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_valid = 0; if_ir = '0; if_pc = '0;
    flush = 0; ex_memread = 0; ex_rd = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0; dbg_sel = 5'd29;
    #2;
    tick;
    rst = 1'b0;
    #1;
    check("rst_sp", dbg_data, 32'd508);
    dbg_sel = 5'd5; #1;
    check("rst_r5", dbg_data, 32'd0);
    check("rst_valid", dx_valid, 0);
    check("rst_ctl", ctl, 0);
    check("rst_alu", dx_aluctr, 0);
    check("rst_data", {dx_a, dx_b}, 0);
    check("rst_jt", dx_jt, 0);
    check("rst_ill", dx_illegal, 0);

    // addi $3,$0,7
    if_valid = 1; if_ir = 32'h2003_0007; if_pc = 32'h4;
    tick;
    check("addi_ctl", ctl, 7'b0100000);
    check("addi_rd", dx_rd, 3);
    check("addi_b", dx_b, 7);
    check("addi_valid", dx_valid, 1);
    // WB of $3 = 7
    if_valid = 0; wb_we = 1; wb_rd = 3; wb_data = 7;
    tick;
    wb_we = 0;
    // add $4,$3,$3
    if_valid = 1; if_ir = 32'h0063_2020; if_pc = 32'h8;
    tick;
    check("add_a", dx_a, 7);
    check("add_b", dx_b, 7);
    check("add_rd", dx_rd, 4);
    check("add_alu", dx_aluctr, 0);
    check("add_ctl", ctl, 7'b0100000);

    // add $6,$5,$5 with $5 written 9 in the same cycle
`ifdef ID_BYPASS_EN
    byp = 32'd9;
`else
    byp = 32'd0;
`endif
    if_ir = 32'h00A5_3020; wb_we = 1; wb_rd = 5; wb_data = 9;
    dbg_sel = 5'd5; #1;
    check("byp_dbg", dbg_data, byp);
    tick;
    wb_we = 0;
    check("byp_a", dx_a, byp);
    check("byp_b", dx_b, byp);
    check("r5_after", dbg_data, 9);

    // load-use on $3: add $4,$3,$0
    if_ir = 32'h0060_2020; ex_memread = 1; ex_rd = 3; #1;
    check("lu_stall", id_stall, 1);
    tick;
    check("lu_bubble_v", dx_valid, 0);
    check("lu_bubble_c", ctl, 0);
    ex_memread = 0; #1;
    check("lu_release", id_stall, 0);
    tick;
    check("lu_go_v", dx_valid, 1);
    check("lu_go_a", dx_a, 7);

    // rt-only hazard ignored for addi (rt is destination)
    if_ir = 32'h2003_0001; ex_memread = 1; ex_rd = 3; #1;
    check("lu_addi_rt", id_stall, 0);

    // flush beats stall
    if_ir = 32'h0060_2020; flush = 1; #1;
    check("fl_stall", id_stall, 0);
    tick;
    check("fl_valid", dx_valid, 0);
    check("fl_ctl", ctl, 0);
    check("fl_ill", dx_illegal, 0);
    flush = 0; ex_memread = 0;

    // sw $3,4($0)
    if_ir = 32'hAC03_0004; if_pc = 32'h10;
    tick;
    check("sw_ctl", ctl, 7'b0001000);
    check("sw_md", dx_md, 7);
    check("sw_b", dx_b, 4);
    check("sw_jt", dx_jt, 0);

    // lw $2,8($29)
    if_ir = 32'h8FA2_0008;
    tick;
    check("lw_ctl", ctl, 7'b1110000);
    check("lw_a", dx_a, 508);
    check("lw_rd", dx_rd, 2);

    // jal field 0x100 at pc 0x44
    if_ir = 32'h0C00_0100; if_pc = 32'h44;
    tick;
    check("jal_jt", dx_jt, 32'h400);
    check("jal_rd", dx_rd, 31);
    check("jal_b", dx_b, 32'h44);
    check("jal_alu", dx_aluctr, 7);
    check("jal_ctl", ctl, 7'b0100010);

    // j keeps upper pc bits
    if_ir = 32'h0800_0003; if_pc = 32'hF000_0004;
    tick;
    check("j_jt", dx_jt, 32'hF000_000C);
    check("j_ctl", ctl, 7'b0000010);

    // beq imm -1 at pc 0x20
    if_ir = 32'h1000_FFFF; if_pc = 32'h20;
    tick;
    check("beq_jt", dx_jt, 32'h1C);
    check("beq_ctl", ctl, 7'b0000100);
    check("beq_alu", dx_aluctr, 6);

    // jr $3
    if_ir = 32'h0060_0008;
    tick;
    check("jr_ctl", ctl, 7'b0000011);
    check("jr_jt", dx_jt, 7);

    // illegal opcode 63
    if_ir = 32'hFC03_1234;
    tick;
    check("ill_pulse", dx_illegal, 1);
    check("ill_ctl", ctl, 0);
    if_valid = 0;
    tick;
    check("ill_drop", dx_illegal, 0);
    dbg_sel = 5'd3; #1;
    check("ill_r3", dbg_data, 7);
    dbg_sel = 5'd4; #1;
    check("ill_r4", dbg_data, 0);

    // bad funct
    if_valid = 1; if_ir = 32'h0063_2003;
    tick;
    check("badfn_ill", dx_illegal, 1);
    if_valid = 0;

    // write to $0 ignored
    wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD;
    tick;
    wb_we = 0; dbg_sel = 5'd0; #1;
    check("r0_zero", dbg_data, 0);

    // reset wins over a same-cycle write
    rst = 1; wb_we = 1; wb_rd = 3; wb_data = 32'h55;
    tick;
    rst = 0; wb_we = 0; dbg_sel = 5'd3; #1;
    check("rst_prio", dbg_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
